reg_c_sequencer: RTL and testbench

Controller that sequences one serial checksum datapath, the 15-bit shift/XOR register with inputs shift, data_in and rst and outputs count and data_out.
- Accepts a frame of N bits over a valid/ready handshake and latches it.
- Clears the datapath, then drives shift for exactly N+PAD cycles.
- Captures the 15-bit result and presents it over a second valid/ready handshake.
- Sits between the frame source and the result consumer; one frame in flight at a time.

---
 rtl/reg_c_sequencer_if.sv | 22 ++
 rtl/reg_c_sequencer.sv | 108 ++++++++++
 tb/tb_reg_c_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_c_sequencer_if.sv
// Frame-in and result-out valid/ready channels of reg_c_sequencer.
// The sequencer takes the slave side; the frame source / result consumer take the master side.
interface reg_c_sequencer_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         res_valid;
    logic         res_ready;
    logic [14:0]  res_data;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/reg_c_sequencer.sv
// Sequencer for the 15-bit serial checksum datapath: latch a frame, clear, shift N+PAD bits, capture, hand off.
// Optional datapath count check is enabled by defining REG_C_SEQ_COUNT_CHECK_EN.
module reg_c_sequencer #(
    parameter int N   = 64,
    parameter int PAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    reg_c_sequencer_if.slave bus,
    output logic             dp_rst,
    output logic             dp_shift,
    output logic [N-1:0]     dp_data,
    input  logic [6:0]       dp_count,
    input  logic [14:0]      dp_out,
    input  logic             abort,
    output logic             busy,
    output logic             err
);
    localparam int         TOTAL    = N + PAD;
    localparam logic [6:0] CNT_LOAD = 7'(TOTAL - 1);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_CLR   = 5'b00010;
    localparam logic [4:0] S_SHIFT = 5'b00100;
    localparam logic [4:0] S_CAPT  = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    logic [4:0]  state;
    logic [4:0]  state_next;
    logic [6:0]  shift_cnt;
    logic [14:0] res_q;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.in_valid;

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_next = S_CLR;
            S_CLR:   state_next = abort ? S_IDLE : S_SHIFT;
            S_SHIFT: begin
                if (abort)               state_next = S_IDLE;
                else if (shift_cnt == '0) state_next = S_CAPT;
            end
            S_CAPT:  state_next = abort ? S_IDLE : S_DONE;
            S_DONE:  if (abort || bus.res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dp_rst    <= 1'b1;
            dp_shift  <= 1'b0;
            dp_data   <= '0;
            shift_cnt <= '0;
            res_q     <= '0;
        end else begin
            state    <= state_next;
            // Datapath controls are decoded from the next state so they leave flops glitch-free.
            dp_rst   <= (state_next == S_IDLE) || (state_next == S_CLR);
            dp_shift <= (state_next == S_SHIFT);

            if (accept) dp_data <= bus.in_data;

            if (state == S_CLR)
                shift_cnt <= CNT_LOAD;
            else if ((state == S_SHIFT) && (shift_cnt != '0))
                shift_cnt <= shift_cnt - 7'd1;

            if ((state == S_CAPT) && !abort) res_q <= dp_out;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.res_valid = (state == S_DONE);
    assign bus.res_data  = res_q;
    assign busy          = (state != S_IDLE);

`ifdef REG_C_SEQ_COUNT_CHECK_EN
    localparam logic [6:0] CNT_EXPECT = 7'(TOTAL % 128);

    logic err_q;

    // Sticky until the next frame is accepted; the result is delivered regardless.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if ((state == S_CAPT) && (dp_count != CNT_EXPECT))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_dp_count;

    assign unused_dp_count = ^dp_count;
    assign err             = 1'b0;
`endif

    a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state));
    a_ctrl_exclusive: assert property (@(posedge clk) disable iff (rst) !(dp_rst && dp_shift));
endmodule

// File: tb/tb_reg_c_sequencer.sv
// Self-checking bench for reg_c_sequencer: two instances (PAD=0 and PAD=15), each with a behavioural datapath model.
// Table-driven frames plus hand-written abort, reset, back-to-back and count-check sequences.
module tb_reg_c_sequencer;
    localparam int N     = 64;
    localparam int PAD_B = 15;
    localparam logic [14:0] POLY = 15'h4599;

`ifdef REG_C_SEQ_COUNT_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [1:0]   in_valid, in_ready, res_valid, res_ready;
    logic [1:0]   dp_rst, dp_shift, abort, busy, err, cnt_force;
    logic [N-1:0] in_data [2];
    logic [N-1:0] dp_data [2];
    logic [6:0]   dp_count [2];
    logic [14:0]  dp_out [2];
    logic [14:0]  res_data [2];

    int checks = 0;
    int passes = 0;
    int xfer_cnt [2];
    int push_cnt [2];
    logic [14:0] exp_q0 [$];
    logic [14:0] exp_q1 [$];

    typedef struct {
        logic [N-1:0] frame;
        int           ready_delay;
        logic         abort_idle;
        logic [14:0]  exp_res;
        int           exp_lat;
        int           exp_shifts;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    function automatic logic [14:0] crc_step(logic [14:0] c, logic b);
        logic fb;
        fb = c[14] ^ b;
        return {c[13:0], 1'b0} ^ (fb ? POLY : 15'h0);
    endfunction

    function automatic logic [14:0] ref_crc(logic [N-1:0] f, int pad);
        logic [14:0] c;
        c = '0;
        for (int i = N - 1; i >= 0; i--) c = crc_step(c, f[i]);
        for (int i = 0; i < pad; i++) c = crc_step(c, 1'b0);
        return c;
    endfunction

    function automatic logic frame_bit(logic [N-1:0] f, logic [6:0] cnt);
        int idx;
        idx = N - 1 - int'(cnt);
        return (idx >= 0) ? f[idx] : 1'b0;
    endfunction

    function automatic int pad_of(int d);
        return (d == 0) ? 0 : PAD_B;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_c_sequencer_if #(.N(N)) bus ();
        logic [14:0] crc_q;
        logic [6:0]  cnt_q;

        assign bus.in_valid  = in_valid[g];
        assign bus.in_data   = in_data[g];
        assign bus.res_ready = res_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign res_valid[g]  = bus.res_valid;
        assign res_data[g]   = bus.res_data;

        reg_c_sequencer #(.N(N), .PAD(g == 0 ? 0 : PAD_B)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .dp_rst   (dp_rst[g]),
            .dp_shift (dp_shift[g]),
            .dp_data  (dp_data[g]),
            .dp_count (dp_count[g]),
            .dp_out   (dp_out[g]),
            .abort    (abort[g]),
            .busy     (busy[g]),
            .err      (err[g])
        );

        // Datapath model: clear on rst, otherwise shift one frame bit (MSB first, then zeros) per shift cycle.
        always @(posedge clk) begin
            if (dp_rst[g]) begin
                crc_q <= '0;
                cnt_q <= '0;
            end else if (dp_shift[g]) begin
                crc_q <= crc_step(crc_q, frame_bit(dp_data[g], cnt_q));
                cnt_q <= cnt_q + 7'd1;
            end
        end

        assign dp_out[g]   = crc_q;
        assign dp_count[g] = cnt_force[g] ? 7'd63 : cnt_q;
    end

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        else
            passes++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int d, logic [14:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
        push_cnt[d]++;
    endtask

    function automatic int exp_size(int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [14:0] pop_exp(int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Scoreboard: a transfer happens at the next rising edge whenever valid&ready are seen here.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst === 1'b0 && res_valid[d] === 1'b1 && res_ready[d] === 1'b1) begin
                xfer_cnt[d]++;
                if (exp_size(d) > 0)
                    check($sformatf("result_dut%0d", d), res_data[d], pop_exp(d));
            end
        end
    end

    // Offer one frame in an IDLE cycle; returns in the CLR cycle (cycle 1).
    task automatic offer(int d, logic [N-1:0] f, logic [14:0] exp, logic push, logic with_abort);
        check($sformatf("in_ready_idle_dut%0d", d), in_ready[d], 1);
        in_valid[d] = 1'b1;
        in_data[d]  = f;
        abort[d]    = with_abort;
        if (push) push_exp(d, exp);
        tick();
        in_valid[d] = 1'b0;
        abort[d]    = 1'b0;
    endtask

    task automatic wait_valid(int d, output int cyc, output int shifts, output int bad);
        cyc = 1;
        shifts = 0;
        bad = 0;
        while (res_valid[d] !== 1'b1 && cyc < 400) begin
            if (dp_shift[d]) shifts++;
            if (dp_shift[d] && dp_rst[d]) bad++;
            if (in_ready[d] || !busy[d]) bad++;
            if (cyc == 1 && (!dp_rst[d] || dp_shift[d])) bad++;
            tick();
            cyc++;
        end
    endtask

    task automatic collect(int d, int exp_lat, int exp_shifts, int delay);
        int cyc, shifts, bad;
        logic [14:0] held;
        wait_valid(d, cyc, shifts, bad);
        check($sformatf("latency_dut%0d", d), cyc, exp_lat);
        check($sformatf("shift_cycles_dut%0d", d), shifts, exp_shifts);
        check($sformatf("ctrl_during_frame_dut%0d", d), bad, 0);
        held = res_data[d];
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            if (res_valid[d] !== 1'b1 || res_data[d] !== held || in_ready[d] || !busy[d]) bad++;
            tick();
        end
        if (delay > 0) check($sformatf("result_held_dut%0d", d), bad, 0);
        res_ready[d] = 1'b1;
        tick();
        res_ready[d] = 1'b0;
        check($sformatf("idle_after_xfer_dut%0d", d),
              {res_valid[d], in_ready[d], busy[d], dp_rst[d], dp_shift[d]}, 5'b01010);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, shifts, bad;
        logic [N-1:0] f1, f2;

        vecs[0] = '{64'h8000_0000_0000_0001, 0, 1'b0, ref_crc(64'h8000_0000_0000_0001, 0), 67, 64};
        vecs[1] = '{64'h0000_0000_0000_0000, 2, 1'b0, ref_crc(64'h0000_0000_0000_0000, 0), 67, 64};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, ref_crc(64'hFFFF_FFFF_FFFF_FFFF, 0), 67, 64};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 3, 1'b0, ref_crc(64'h0123_4567_89AB_CDEF, 0), 67, 64};
        vecs[4] = '{64'hDEAD_BEEF_0000_0001, 1, 1'b0, ref_crc(64'hDEAD_BEEF_0000_0001, 0), 67, 64};

        rst = 1'b1;
        in_valid = '0;
        res_ready = '0;
        abort = '0;
        cnt_force = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        xfer_cnt = '{0, 0};
        push_cnt = '{0, 0};
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ctrl_dut%0d", d),
                  {in_ready[d], busy[d], dp_rst[d], dp_shift[d], res_valid[d], err[d]}, 6'b101000);
            check($sformatf("reset_dp_data_dut%0d", d), dp_data[d], 0);
            check($sformatf("reset_res_data_dut%0d", d), res_data[d], 0);
        end

        for (int i = 0; i < 5; i++) begin
            offer(0, vecs[i].frame, vecs[i].exp_res, 1'b1, vecs[i].abort_idle);
            check("dp_data_latched", dp_data[0], vecs[i].frame);
            collect(0, vecs[i].exp_lat, vecs[i].exp_shifts, vecs[i].ready_delay);
        end

        // PAD=15 instance with the consumer stalling for 10 cycles.
        f1 = 64'h8000_0000_0000_0001;
        offer(1, f1, ref_crc(f1, PAD_B), 1'b1, 1'b0);
        collect(1, N + PAD_B + 3, N + PAD_B, 10);

        // Abort in the 20th SHIFT cycle, then a fresh frame in the following IDLE cycle.
        offer(0, 64'hA5A5_0F0F_3C3C_9999, '0, 1'b0, 1'b0);
        repeat (20) tick();
        check("shift_before_abort", dp_shift[0], 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("after_abort", {dp_shift[0], dp_rst[0], busy[0], in_ready[0], res_valid[0]}, 5'b01010);
        f2 = 64'h1357_9BDF_2468_ACE0;
        offer(0, f2, ref_crc(f2, 0), 1'b1, 1'b0);
        collect(0, 67, 64, 0);

        // Abort in DONE without res_ready: back to IDLE with no transfer.
        offer(0, 64'h0F0F_0F0F_F0F0_F0F0, '0, 1'b0, 1'b0);
        wait_valid(0, cyc, shifts, bad);
        check("done_reached_for_abort", res_valid[0], 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("after_done_abort", {res_valid[0], in_ready[0], busy[0]}, 3'b010);

        // Back-to-back frames with in_valid and res_ready held high.
        f1 = 64'hCAFE_BABE_1234_5678;
        f2 = 64'h0000_FFFF_0000_FFFF;
        check("b2b_idle_start", in_ready[0], 1);
        in_valid[0] = 1'b1;
        in_data[0] = f1;
        res_ready[0] = 1'b1;
        push_exp(0, ref_crc(f1, 0));
        push_exp(0, ref_crc(f2, 0));
        tick();
        in_data[0] = f2;
        wait_valid(0, cyc, shifts, bad);
        check("b2b_first_latency", cyc, 67);
        tick();
        check("b2b_idle_gap", {in_ready[0], busy[0], res_valid[0]}, 3'b100);
        tick();
        in_valid[0] = 1'b0;
        check("b2b_second_accept", {in_ready[0], busy[0], dp_rst[0]}, 3'b011);
        check("b2b_second_data", dp_data[0], f2);
        wait_valid(0, cyc, shifts, bad);
        check("b2b_second_latency", cyc, 67);
        check("b2b_second_shifts", shifts, 64);
        tick();
        res_ready[0] = 1'b0;
        check("b2b_final_idle", {res_valid[0], in_ready[0]}, 2'b01);

        // Count check: datapath reports 63 instead of 64 in CAPT.
        f1 = 64'h8000_0000_0000_0001;
        cnt_force[0] = 1'b1;
        offer(0, f1, ref_crc(f1, 0), 1'b1, 1'b0);
        collect(0, 67, 64, 0);
        check("err_after_count_mismatch", err[0], ERR_EN);
        cnt_force[0] = 1'b0;
        offer(0, f2, ref_crc(f2, 0), 1'b1, 1'b0);
        check("err_cleared_on_accept", err[0], 0);
        collect(0, 67, 64, 0);

        // Reset asserted while in CAPT abandons the frame.
        offer(0, 64'h7777_8888_9999_AAAA, '0, 1'b0, 1'b0);
        repeat (65) tick();
        check("in_capt", {res_valid[0], dp_shift[0], dp_rst[0], busy[0]}, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_in_capt", {dp_rst[0], dp_shift[0], res_valid[0], busy[0], in_ready[0], err[0]}, 6'b100010);
        check("reset_in_capt_res_data", res_data[0], 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
            tick();
        end
        check("no_result_after_reset", bad, 0);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("xfer_count_dut%0d", d), xfer_cnt[d], push_cnt[d]);
            check($sformatf("scoreboard_drained_dut%0d", d), exp_size(d), 0);
            check($sformatf("err_final_dut%0d", d), err[d], 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
